usb_dev_responder: RTL and testbench



---
 rtl/usb_pkg.sv | 33 +++
 rtl/usb_dev_timeout.sv | 25 ++
 rtl/usb_dev_responder.sv | 163 ++++++++++++++++
 tb/tb_usb_dev_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB packet-level definitions: PID codes, device responder states and
// the default device address / endpoint assignments.
package usb_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010
    } usb_pid_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_MEM_WR,
        ST_MEM_RD,
        ST_SEND_DATA,
        ST_WAIT_ACK,
        ST_SEND_HS
    } usb_state_t;

    localparam logic [6:0]  USB_DEV_ADDR  = 7'd5;
    localparam logic [3:0]  USB_ADDR_ENDP = 4'd4;
    localparam logic [3:0]  USB_DATA_ENDP = 4'd8;
    localparam int unsigned USB_TIMEOUT   = 255;

    // DATA0/DATA1/DATA2/MDATA all end in 2'b11.
    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/usb_dev_timeout.sv
// 8-bit cycle counter: cleared by i_clr, counts while i_en, and flags
// o_expired on the LIMIT-th enabled cycle since the last clear.
module usb_dev_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [7:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = i_en && (r_count == 8'(LIMIT - 1));

endmodule

// File: rtl/usb_dev_responder.sv
// Device-side USB endpoint responder: address phase on ADDR_ENDP, 64-bit
// memory writes (OUT) and reads (IN) on DATA_ENDP.
module usb_dev_responder
    import usb_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = USB_DEV_ADDR,
    parameter logic [3:0]  ADDR_ENDP = USB_ADDR_ENDP,
    parameter logic [3:0]  DATA_ENDP = USB_DATA_ENDP,
    parameter int unsigned TIMEOUT   = USB_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [3:0]  rx_pid,
    input  logic [6:0]  rx_addr,
    input  logic [3:0]  rx_endp,
    input  logic [63:0] rx_data,
    input  logic        rx_crc_ok,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [3:0]  tx_pid,
    output logic [63:0] tx_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack
);

    usb_state_t  r_state;
    logic [15:0] r_addr_reg;
    logic        r_to_addr_ep;
    logic        r_tx_valid;
    logic [3:0]  r_tx_pid;
    logic [63:0] r_tx_data;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [63:0] r_mem_wdata;

    logic w_waiting;
    logic w_expired;
    logic w_token_for_us;

    // Only the two listening states count; every other state holds the
    // counter at zero, so each entry into a listening state starts fresh.
    assign w_waiting = (r_state == ST_WAIT_DATA) || (r_state == ST_WAIT_ACK);

    usb_dev_timeout #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clr     (!w_waiting),
        .i_en      (w_waiting),
        .o_expired (w_expired)
    );

    assign w_token_for_us = rx_valid && rx_crc_ok && (rx_addr == DEV_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr_reg   <= '0;
            r_to_addr_ep <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_tx_pid     <= '0;
            r_tx_data    <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_token_for_us) begin
                        if (rx_pid == PID_OUT &&
                            (rx_endp == ADDR_ENDP || rx_endp == DATA_ENDP)) begin
                            r_to_addr_ep <= (rx_endp == ADDR_ENDP);
                            r_state      <= ST_WAIT_DATA;
                        end else if (rx_pid == PID_IN && rx_endp == DATA_ENDP) begin
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= r_addr_reg;
                            r_state    <= ST_MEM_RD;
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    if (rx_valid && is_data_pid(rx_pid)) begin
                        if (rx_pid == PID_DATA0 && rx_crc_ok) begin
                            if (r_to_addr_ep) begin
                                r_addr_reg <= rx_data[15:0];
                                r_tx_valid <= 1'b1;
                                r_tx_pid   <= PID_ACK;
                                r_state    <= ST_SEND_HS;
                            end else begin
                                r_mem_req   <= 1'b1;
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= r_addr_reg;
                                r_mem_wdata <= rx_data;
                                r_state     <= ST_MEM_WR;
                            end
                        end else begin
                            r_tx_valid <= 1'b1;
                            r_tx_pid   <= PID_NAK;
                            r_state    <= ST_SEND_HS;
                        end
                    end else if (w_expired) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MEM_WR: begin
                    if (mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_tx_valid <= 1'b1;
                        r_tx_pid   <= PID_ACK;
                        r_state    <= ST_SEND_HS;
                    end
                end
                ST_MEM_RD: begin
                    if (mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_tx_valid <= 1'b1;
                        r_tx_pid   <= PID_DATA0;
                        r_tx_data  <= mem_rdata;
                        r_state    <= ST_SEND_DATA;
                    end
                end
                ST_SEND_DATA: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // ACK, NAK, anything else or silence all end the read;
                    // a retry arrives as a fresh IN and re-reads memory.
                    if (rx_valid || w_expired) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SEND_HS: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_valid  = r_tx_valid;
    assign tx_pid    = r_tx_pid;
    assign tx_data   = r_tx_data;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_usb_dev_responder.sv
// Directed self-checking bench for usb_dev_responder: inputs change and
// outputs are sampled on the falling clock edge.
module tb_usb_dev_responder;
    import usb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [3:0]  rx_pid;
    logic [6:0]  rx_addr;
    logic [3:0]  rx_endp;
    logic [63:0] rx_data;
    logic        rx_crc_ok;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  tx_pid;
    logic [63:0] tx_data;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    usb_dev_responder dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_pid    (rx_pid),
        .rx_addr   (rx_addr),
        .rx_endp   (rx_endp),
        .rx_data   (rx_data),
        .rx_crc_ok (rx_crc_ok),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_pid    (tx_pid),
        .tx_data   (tx_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [3:0] pid, input logic [6:0] a, input logic [3:0] e,
                            input logic [63:0] d, input logic crc);
        rx_valid  = 1'b1;
        rx_pid    = pid;
        rx_addr   = a;
        rx_endp   = e;
        rx_data   = d;
        rx_crc_ok = crc;
        tick(1);
        rx_valid  = 1'b0;
        rx_pid    = '0;
        rx_data   = '0;
    endtask

    // Expects a pending request already visible, holds it for two cycles, then acks.
    task automatic serve_mem(input string tag, input logic exp_we, input logic [15:0] exp_addr,
                             input logic [63:0] exp_wdata, input logic chk_wdata,
                             input logic [63:0] rdata);
        int k;
        k = 0;
        while (!mem_req && k < 20) begin
            tick(1);
            k++;
        end
        check({tag, " mem_req"}, 64'(mem_req), 64'd1);
        check({tag, " mem_we"}, 64'(mem_we), 64'(exp_we));
        check({tag, " mem_addr"}, 64'(mem_addr), 64'(exp_addr));
        if (chk_wdata) check({tag, " mem_wdata"}, mem_wdata, exp_wdata);
        tick(2);
        check({tag, " mem_req held"}, 64'(mem_req), 64'd1);
        check({tag, " mem_addr held"}, 64'(mem_addr), 64'(exp_addr));
        mem_rdata = rdata;
        mem_ack   = 1'b1;
        tick(1);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check({tag, " mem_req drop"}, 64'(mem_req), 64'd0);
    endtask

    // Expects tx_valid already up, stalls the transmitter two cycles, then accepts.
    task automatic accept_tx(input string tag, input logic [3:0] exp_pid,
                             input logic [63:0] exp_data, input logic chk_data);
        check({tag, " tx_valid"}, 64'(tx_valid), 64'd1);
        check({tag, " tx_pid"}, 64'(tx_pid), 64'(exp_pid));
        if (chk_data) check({tag, " tx_data"}, tx_data, exp_data);
        tick(2);
        check({tag, " tx_valid held"}, 64'(tx_valid), 64'd1);
        check({tag, " tx_pid held"}, 64'(tx_pid), 64'(exp_pid));
        tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0;
        check({tag, " tx_valid drop"}, 64'(tx_valid), 64'd0);
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        logic seen_tx;
        logic seen_mem;
        seen_tx  = 1'b0;
        seen_mem = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (tx_valid) seen_tx = 1'b1;
            if (mem_req) seen_mem = 1'b1;
            tick(1);
        end
        check({tag, " no tx_valid"}, 64'(seen_tx), 64'd0);
        check({tag, " no mem_req"}, 64'(seen_mem), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " tx_valid"}, 64'(tx_valid), 64'd0);
        check({tag, " tx_pid"}, 64'(tx_pid), 64'd0);
        check({tag, " tx_data"}, tx_data, 64'd0);
        check({tag, " mem_req"}, 64'(mem_req), 64'd0);
        check({tag, " mem_we"}, 64'(mem_we), 64'd0);
        check({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, " mem_wdata"}, mem_wdata, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0; rx_pid = '0; rx_addr = '0; rx_endp = '0; rx_data = '0; rx_crc_ok = 1'b0;
        tx_ready = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(1);

        // Read before any address phase uses address 0.
        send_pkt(4'b1001, 7'd5, 4'd8, '0, 1'b1);
        serve_mem("rd0", 1'b0, 16'h0000, '0, 1'b0, 64'h0123_4567_89AB_CDEF);
        accept_tx("rd0 data", 4'b0011, 64'h0123_4567_89AB_CDEF, 1'b1);
        send_pkt(4'b0010, 7'd0, 4'd0, '0, 1'b1);

        // Address phase.
        send_pkt(4'b0001, 7'd5, 4'd4, '0, 1'b1);
        check("addr out no tx", 64'(tx_valid), 64'd0);
        send_pkt(4'b0011, 7'd0, 4'd0, 64'h0000_0000_0000_FFFF, 1'b1);
        check("addr no mem_req", 64'(mem_req), 64'd0);
        accept_tx("addr ack", 4'b0010, '0, 1'b0);
        check("addr after no mem_req", 64'(mem_req), 64'd0);

        // Write to the latched address.
        send_pkt(4'b0001, 7'd5, 4'd8, '0, 1'b1);
        send_pkt(4'b0011, 7'd0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check("wr req latency", 64'(mem_req), 64'd1);
        serve_mem("wr", 1'b1, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, '0);
        accept_tx("wr ack", 4'b0010, '0, 1'b0);

        // Read, host ACK.
        send_pkt(4'b1001, 7'd5, 4'd8, '0, 1'b1);
        check("rd req latency", 64'(mem_req), 64'd1);
        serve_mem("rd1", 1'b0, 16'hFFFF, '0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        accept_tx("rd1 data", 4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        send_pkt(4'b0010, 7'd0, 4'd0, '0, 1'b1);

        // Read, host NAK, retry re-reads memory.
        send_pkt(4'b1001, 7'd5, 4'd8, '0, 1'b1);
        serve_mem("rd2", 1'b0, 16'hFFFF, '0, 1'b0, 64'hA5A5_0000_1111_2222);
        accept_tx("rd2 data", 4'b0011, 64'hA5A5_0000_1111_2222, 1'b1);
        send_pkt(4'b1010, 7'd0, 4'd0, '0, 1'b1);
        send_pkt(4'b1001, 7'd5, 4'd8, '0, 1'b1);
        serve_mem("rd3", 1'b0, 16'hFFFF, '0, 1'b0, 64'h5A5A_3333_4444_5555);
        accept_tx("rd3 data", 4'b0011, 64'h5A5A_3333_4444_5555, 1'b1);
        send_pkt(4'b0010, 7'd0, 4'd0, '0, 1'b1);

        // Bad CRC data and DATA1 are NAKed without touching memory.
        send_pkt(4'b0001, 7'd5, 4'd8, '0, 1'b1);
        send_pkt(4'b0011, 7'd0, 4'd0, 64'h1234, 1'b0);
        check("badcrc no mem_req", 64'(mem_req), 64'd0);
        accept_tx("badcrc nak", 4'b1010, '0, 1'b0);
        send_pkt(4'b0001, 7'd5, 4'd8, '0, 1'b1);
        send_pkt(4'b1011, 7'd0, 4'd0, 64'h1234, 1'b1);
        check("data1 no mem_req", 64'(mem_req), 64'd0);
        accept_tx("data1 nak", 4'b1010, '0, 1'b0);

        // Ignored tokens: foreign address, bad CRC, unsupported endpoint.
        send_pkt(4'b0001, 7'd3, 4'd8, '0, 1'b1);
        send_pkt(4'b0011, 7'd0, 4'd0, 64'h77, 1'b1);
        check_quiet("foreign out", 4);
        send_pkt(4'b1001, 7'd3, 4'd8, '0, 1'b1);
        check_quiet("foreign in", 4);
        send_pkt(4'b1001, 7'd5, 4'd8, '0, 1'b0);
        check_quiet("badcrc in", 4);
        send_pkt(4'b1001, 7'd5, 4'd4, '0, 1'b1);
        check_quiet("in endp4", 4);

        // Timeout boundary: data on the 255th waiting cycle is still taken.
        send_pkt(4'b0001, 7'd5, 4'd8, '0, 1'b1);
        check_quiet("wait254", 254);
        send_pkt(4'b0011, 7'd0, 4'd0, 64'h99, 1'b0);
        accept_tx("last-cycle nak", 4'b1010, '0, 1'b0);

        // One cycle later the transaction has been abandoned.
        send_pkt(4'b0001, 7'd5, 4'd8, '0, 1'b1);
        check_quiet("wait255", 255);
        send_pkt(4'b0011, 7'd0, 4'd0, 64'h99, 1'b1);
        check_quiet("after timeout", 4);
        send_pkt(4'b0001, 7'd5, 4'd4, '0, 1'b1);
        send_pkt(4'b0011, 7'd0, 4'd0, 64'h0000_0000_0000_00C3, 1'b1);
        accept_tx("post-timeout ack", 4'b0010, '0, 1'b0);

        // Reset while a read is pending; late ack ignored, addr_reg back to 0.
        send_pkt(4'b1001, 7'd5, 4'd8, '0, 1'b1);
        check("pre-rst mem_req", 64'(mem_req), 64'd1);
        check("pre-rst mem_addr", 64'(mem_addr), 64'h00C3);
        rst = 1'b1;
        tick(1);
        check_all_zero("mid rst");
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        tick(1);
        mem_ack = 1'b0;
        mem_rdata = '0;
        check_quiet("late ack", 4);
        send_pkt(4'b1001, 7'd5, 4'd8, '0, 1'b1);
        serve_mem("rd after rst", 1'b0, 16'h0000, '0, 1'b0, 64'h1);
        accept_tx("rd after rst data", 4'b0011, 64'h1, 1'b1);
        send_pkt(4'b0010, 7'd0, 4'd0, '0, 1'b1);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
